// File: rtl/can_bit_destuffer.sv
`default_nettype none
// ============================================================================
//  Module      : can_bit_destuffer
//  Description : CAN receive-side bit de-stuffer. Removes the complementary
//                stuff bit that follows STUFF_LEN equal bits inside the
//                stuffed region and flags a sticky stuff error when that bit
//                does not toggle. All outputs are registered (1 clk latency).
//  Revision    : 1.0 - initial release
// ============================================================================
module can_bit_destuffer #(
  parameter int STUFF_LEN = 5,
  parameter int CNT_W     = 3
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sample_point_i,
  input  logic rx_bit_i,
  input  logic destuff_en_i,
  input  logic clear_i,
  output logic bit_out_o,
  output logic bit_valid_o,
  output logic stuff_removed_o,
  output logic stuff_pending_o,
  output logic stuff_err_o
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_COUNT = 2'd1;
  localparam logic [1:0] c_ERROR = 2'd2;

  localparam logic [CNT_W-1:0] c_STUFF_CNT = CNT_W'(STUFF_LEN);
  localparam logic [CNT_W-1:0] c_ONE       = CNT_W'(1);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
  logic             last_bit_q, last_bit_d;
  logic             bit_out_q, bit_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             stuff_removed_q, stuff_removed_d;
  logic             stuff_pending_q, stuff_pending_d;
  logic             stuff_err_q, stuff_err_d;

  // Next-state decode: clear beats sample_point; only sample_point advances state.
  always_comb begin
    state_d         = state_q;
    run_cnt_d       = run_cnt_q;
    last_bit_d      = last_bit_q;
    bit_out_d       = bit_out_q;
    bit_valid_d     = 1'b0;
    stuff_removed_d = 1'b0;
    stuff_err_d     = stuff_err_q;

    if (clear_i) begin
      state_d     = c_IDLE;
      run_cnt_d   = '0;
      last_bit_d  = 1'b1;
      stuff_err_d = 1'b0;
    end else if (sample_point_i) begin
      case (state_q)
        c_IDLE: begin
          bit_out_d   = rx_bit_i;
          bit_valid_d = 1'b1;
          if (destuff_en_i) begin
            run_cnt_d  = c_ONE;
            last_bit_d = rx_bit_i;
            state_d    = c_COUNT;
          end
        end
        c_COUNT: begin
          if (!destuff_en_i) begin
            // Window closed: pass the bit through and forget the run.
            bit_out_d   = rx_bit_i;
            bit_valid_d = 1'b1;
            run_cnt_d   = '0;
            state_d     = c_IDLE;
          end else if (run_cnt_q != c_STUFF_CNT) begin
            bit_out_d   = rx_bit_i;
            bit_valid_d = 1'b1;
            run_cnt_d   = (rx_bit_i == last_bit_q) ? run_cnt_q + c_ONE : c_ONE;
            last_bit_d  = rx_bit_i;
          end else if (rx_bit_i != last_bit_q) begin
            // Legal stuff bit: drop it, it opens the next run.
            stuff_removed_d = 1'b1;
            run_cnt_d       = c_ONE;
            last_bit_d      = rx_bit_i;
          end else begin
            stuff_err_d = 1'b1;
            state_d     = c_ERROR;
          end
        end
        default: begin
          // ERROR (and any unused encoding) ignores samples until cleared.
          state_d = c_ERROR;
        end
      endcase
    end

    stuff_pending_d = (state_d == c_COUNT) && (run_cnt_d == c_STUFF_CNT);
  end

  // State and output registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= c_IDLE;
      run_cnt_q       <= '0;
      last_bit_q      <= 1'b1;
      bit_out_q       <= 1'b1;
      bit_valid_q     <= 1'b0;
      stuff_removed_q <= 1'b0;
      stuff_pending_q <= 1'b0;
      stuff_err_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      run_cnt_q       <= run_cnt_d;
      last_bit_q      <= last_bit_d;
      bit_out_q       <= bit_out_d;
      bit_valid_q     <= bit_valid_d;
      stuff_removed_q <= stuff_removed_d;
      stuff_pending_q <= stuff_pending_d;
      stuff_err_q     <= stuff_err_d;
    end
  end

  assign bit_out_o       = bit_out_q;
  assign bit_valid_o     = bit_valid_q;
  assign stuff_removed_o = stuff_removed_q;
  assign stuff_pending_o = stuff_pending_q;
  assign stuff_err_o     = stuff_err_q;

endmodule
`default_nettype wire

// File: tb/tb_can_bit_destuffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_can_bit_destuffer
//  Description : Self-checking bench for can_bit_destuffer. A queue-based
//                model of the stuffing rule predicts every output each cycle;
//                directed scenarios pin the model with literal expectations,
//                followed by biased random traffic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_can_bit_destuffer;

  localparam int L = 5;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sample_point = 1'b0;
  logic rx_bit = 1'b1;
  logic destuff_en = 1'b0;
  logic clear = 1'b0;
  logic bit_out, bit_valid, stuff_removed, stuff_pending, stuff_err;

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  can_bit_destuffer #(.STUFF_LEN(L), .CNT_W(3)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .sample_point_i  (sample_point),
    .rx_bit_i        (rx_bit),
    .destuff_en_i    (destuff_en),
    .clear_i         (clear),
    .bit_out_o       (bit_out),
    .bit_valid_o     (bit_valid),
    .stuff_removed_o (stuff_removed),
    .stuff_pending_o (stuff_pending),
    .stuff_err_o     (stuff_err)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // q holds the bits of the current run history inside the window; a stuff
  // position is reached when its last L entries are all equal.
  bit   q[$];
  logic m_bit_out = 1'b1, m_valid = 1'b0, m_removed = 1'b0, m_pend = 1'b0, m_err = 1'b0;

  function automatic int run_len();
    int n = 0;
    for (int i = q.size() - 1; i >= 0; i--) begin
      if (q[i] != q[q.size()-1]) break;
      n++;
    end
    return n;
  endfunction

  task automatic model_step(input logic sp, input logic b, input logic en, input logic clr);
    m_valid   = 1'b0;
    m_removed = 1'b0;
    if (clr) begin
      q.delete();
      m_err = 1'b0;
    end else if (sp && !m_err) begin
      if (!en) begin
        m_bit_out = b;
        m_valid   = 1'b1;
        q.delete();
      end else if (run_len() == L) begin
        if (b != q[q.size()-1]) begin
          m_removed = 1'b1;
          q.delete();
          q.push_back(b);
        end else begin
          m_err = 1'b1;
          q.delete();
        end
      end else begin
        m_bit_out = b;
        m_valid   = 1'b1;
        q.push_back(b);
        if (q.size() > L) void'(q.pop_front());
      end
    end
    m_pend = !m_err && (run_len() == L);
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_bit_out = 1'b1; m_valid = 1'b0; m_removed = 1'b0; m_pend = 1'b0; m_err = 1'b0;
    end else begin
      model_step(sample_point, rx_bit, destuff_en, clear);
    end
  end

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  bit dq[$];
  int rem_cnt = 0;

  // Per-cycle comparison against the model, plus a log of delivered bits.
  always @(negedge clk) begin
    if (rst_n && started) begin
      chk("bit_valid", 32'(bit_valid), 32'(m_valid));
      chk("stuff_removed", 32'(stuff_removed), 32'(m_removed));
      chk("stuff_pending", 32'(stuff_pending), 32'(m_pend));
      chk("stuff_err", 32'(stuff_err), 32'(m_err));
      chk("bit_out", 32'(bit_out), 32'(m_bit_out));
      if (bit_valid) dq.push_back(bit_out);
      if (stuff_removed) rem_cnt++;
    end
  end

  task automatic step(input logic sp, input logic b, input logic en, input logic clr);
    @(negedge clk);
    sample_point = sp; rx_bit = b; destuff_en = en; clear = clr;
    @(posedge clk);
    #1;
    sample_point = 1'b0; clear = 1'b0;
  endtask

  task automatic feed(input int n, input logic b, input logic en);
    for (int i = 0; i < n; i++) step(1'b1, b, en, 1'b0);
  endtask

  task automatic look();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_log();
    dq.delete();
    rem_cnt = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    sample_point = 1'b0; clear = 1'b0;
    #1;
    chk("rst bit_out", 32'(bit_out), 32'd1);
    chk("rst bit_valid", 32'(bit_valid), 32'd0);
    chk("rst stuff_removed", 32'(stuff_removed), 32'd0);
    chk("rst stuff_pending", 32'(stuff_pending), 32'd0);
    chk("rst stuff_err", 32'(stuff_err), 32'd0);
    @(negedge clk);
    #2 rst_n = 1'b1;
  endtask

  logic [8:0] packed9;
  logic       en_r, prev_b, sp_r, b_r, clr_r;

  initial begin
    #12 rst_n = 1'b1;
    started = 1'b1;

    // Reset in the middle of a run discards the run.
    feed(3, 1'b0, 1'b1);
    do_reset();
    feed(4, 1'b0, 1'b1);
    look();
    chk("after-reset pending after 4", 32'(stuff_pending), 32'd0);
    feed(1, 1'b0, 1'b1);
    look();
    chk("after-reset pending after 5", 32'(stuff_pending), 32'd1);

    // Normal removal: 0x5 then 1 (stuff) then 1.
    do_reset(); clear_log();
    feed(5, 1'b0, 1'b1);
    look();
    chk("normal pending", 32'(stuff_pending), 32'd1);
    feed(1, 1'b1, 1'b1);
    look();
    chk("normal removed", 32'(stuff_removed), 32'd1);
    chk("normal no valid", 32'(bit_valid), 32'd0);
    feed(1, 1'b1, 1'b1);
    feed(3, 1'b1, 1'b1);
    look();
    chk("normal data count", 32'(dq.size()), 32'd9);
    chk("normal run reaches 5", 32'(stuff_pending), 32'd1);

    // Chained stuffing.
    do_reset(); clear_log();
    feed(5, 1'b1, 1'b1);
    feed(1, 1'b0, 1'b1);
    feed(4, 1'b0, 1'b1);
    feed(1, 1'b1, 1'b1);
    look();
    chk("chain removed", 32'(rem_cnt), 32'd2);
    chk("chain count", 32'(dq.size()), 32'd9);
    packed9 = '0;
    for (int i = 0; i < dq.size() && i < 9; i++) packed9[8-i] = dq[i];
    chk("chain bits", 32'(packed9), 32'h1F0);

    // Stuff error and clear.
    do_reset(); clear_log();
    feed(6, 1'b0, 1'b1);
    look();
    chk("err count", 32'(dq.size()), 32'd5);
    chk("err flag", 32'(stuff_err), 32'd1);
    feed(1, 1'b1, 1'b1);
    feed(1, 1'b0, 1'b1);
    look();
    chk("err ignores", 32'(dq.size()), 32'd5);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    look();
    chk("err cleared", 32'(stuff_err), 32'd0);

    // Window edges.
    do_reset(); clear_log();
    feed(8, 1'b1, 1'b0);
    look();
    chk("passthru count", 32'(dq.size()), 32'd8);
    chk("passthru removed", 32'(rem_cnt), 32'd0);
    feed(5, 1'b0, 1'b1);
    feed(1, 1'b0, 1'b0);
    look();
    chk("window close count", 32'(dq.size()), 32'd14);
    chk("window close no err", 32'(stuff_err), 32'd0);

    // Clear together with a sample while a stuff bit is pending.
    do_reset(); clear_log();
    feed(5, 1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    look();
    chk("simul valid", 32'(bit_valid), 32'd0);
    chk("simul removed", 32'(stuff_removed), 32'd0);
    chk("simul pending", 32'(stuff_pending), 32'd0);

    // Biased random traffic: long runs so stuff positions are hit often.
    en_r = 1'b1; prev_b = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        if ($urandom_range(0, 39) == 0) en_r = ~en_r;
        sp_r  = ($urandom_range(0, 9) < 7);
        b_r   = ($urandom_range(0, 9) < 8) ? prev_b : ~prev_b;
        prev_b = b_r;
        clr_r = ($urandom_range(0, 99) < 3);
        step(sp_r, b_r, en_r, clr_r);
      end
    end
    look();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/can_bit_destuffer.md
Name: can_bit_destuffer

Overview:
Receive-side counterpart of the CAN transmit bit stuffer. It watches sampled bus bits inside the stuffed region of a frame (SOF through the end of the CRC sequence) and removes each stuff bit inserted after STUFF_LEN consecutive equal bits. It flags a stuff error when the bit that should be a stuff bit matches the preceding run. It sits between the bit-timing and sampling logic and the receive frame FSM, which consumes only the de-stuffed data bits.

Parameters:
STUFF_LEN, 5, run length of equal bits after which the next bit must be a complementary stuff bit (legal range 2..7).
CNT_W, 3, width of the run counter; must satisfy 2**CNT_W > STUFF_LEN.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
sample_point  input  1  single-cycle strobe; rx_bit is valid in this cycle
rx_bit  input  1  sampled bus bit (0 = dominant, 1 = recessive)
destuff_en  input  1  high while the frame FSM is inside the stuffed region
clear  input  1  synchronous clear; returns block to IDLE and clears stuff_err
bit_out  output  1  de-stuffed data bit, valid when bit_valid = 1
bit_valid  output  1  one-cycle pulse, one per delivered data bit
stuff_removed  output  1  one-cycle pulse when a stuff bit was discarded
stuff_pending  output  1  level; next sampled bit in the window is a stuff bit
stuff_err  output  1  sticky stuff-error flag

Behaviour:
- Reset is asynchronous and active-low. While reset is active or after it releases:
  - outputs: bit_out = 1, bit_valid = 0, stuff_removed = 0, stuff_pending = 0, stuff_err = 0
  - internal state: state = IDLE, run_cnt = 0, last_bit = 1.
- All outputs are registered. Latency is 1 clk: the response to a sample_point in cycle N appears in cycle N+1.
- Only cycles with sample_point = 1 change state. Pulse outputs deassert in every other cycle.
- Priority order: reset, then clear, then sample_point. When clear and sample_point occur in the same cycle, clear wins and the bit is dropped: no bit_valid, state = IDLE, stuff_err = 0.
- States: IDLE, COUNT, ERROR.
- IDLE:
  - On sample_point with destuff_en = 0: pass-through. bit_out = rx_bit, bit_valid = 1; run_cnt stays 0.
  - On sample_point with destuff_en = 1: deliver the bit, set run_cnt = 1, last_bit = rx_bit, go to COUNT.
- COUNT, on sample_point:
  - destuff_en = 0: pass-through as in IDLE, then go to IDLE with run_cnt = 0.
  - run_cnt < STUFF_LEN: deliver the bit. If rx_bit == last_bit, run_cnt += 1; otherwise run_cnt = 1. Set last_bit = rx_bit.
  - run_cnt == STUFF_LEN and rx_bit != last_bit: this is a stuff bit. bit_valid = 0, stuff_removed = 1, run_cnt = 1, last_bit = rx_bit. The stuff bit counts as the first bit of the next run.
  - run_cnt == STUFF_LEN and rx_bit == last_bit: stuff error. bit_valid = 0, stuff_err = 1, go to ERROR.
- ERROR: all sample_points are ignored (no bit_valid, no stuff_removed). Only clear or reset exits this state. stuff_err stays 1.
- stuff_pending = 1 exactly when state == COUNT and run_cnt == STUFF_LEN.
- Window closing: the frame FSM keeps destuff_en high until stuff_pending = 0 after the last CRC bit. This lets a trailing stuff bit after the CRC be removed and checked.
- run_cnt never exceeds STUFF_LEN, and there is no wrap-around.
- bit_out holds its last value when bit_valid = 0.

Test Plan:
- Reset mid-run: destuff_en = 1, feed 0,0,0; assert rst_n = 0 asynchronously -> all outputs go to reset values immediately. After release, the next enabled 0 gives run_cnt = 1, not 4.
- Normal stuff removal: destuff_en = 1, feed 0,0,0,0,0,1,1 -> five bit_valid pulses with bit_out = 0, stuff_pending = 1 after the fifth bit, and stuff_removed on the sixth bit (the 1) with no bit_valid. The seventh bit (1) is delivered and run_cnt = 2.
- Chained stuffing: feed 1×5, stuff 0, 0×4, stuff 1 -> two stuff_removed pulses. Nine data bits are delivered (1,1,1,1,1,0,0,0,0), because the first stuff bit starts the 0-run.
- Stuff error: feed 0×6 -> five data bits, then stuff_err = 1 one cycle after the sixth sample. Following samples 1,0 give no bit_valid. Asserting clear -> stuff_err = 0 and state = IDLE.
- Window edges: with destuff_en = 0, feed 1×8 -> eight bit_valid pulses and no stuff activity. Then raise destuff_en with 0×5 and drop it on the sixth sample (0) -> the sixth bit is delivered and there is no error.
- Simultaneous events: clear and sample_point together while stuff_pending = 1 -> no bit_valid, no stuff_removed, stuff_pending = 0 next cycle.
